// File: rtl/core_alu_seq_pkg.sv
// Shared ALU types for the chunked sequencer: opcodes, PSR flags, and the per-chunk op remap
// that any multi-cycle sequencer can reuse.
package core_alu_seq_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'h0,
    ALU_EOR = 4'h1,
    ALU_SUB = 4'h2,
    ALU_RSB = 4'h3,
    ALU_ADD = 4'h4,
    ALU_ADC = 4'h5,
    ALU_SBC = 4'h6,
    ALU_RSC = 4'h7,
    ALU_TST = 4'h8,
    ALU_TEQ = 4'h9,
    ALU_CMP = 4'hA,
    ALU_CMN = 4'hB,
    ALU_ORR = 4'hC,
    ALU_MOV = 4'hD,
    ALU_BIC = 4'hE,
    ALU_MVN = 4'hF
  } alu_op;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } psr_flags;

  function automatic logic is_arith(alu_op op);
    unique case (op)
      ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC,
      ALU_RSB, ALU_RSC, ALU_CMP, ALU_CMN: is_arith = 1'b1;
      default:                            is_arith = 1'b0;
    endcase
  endfunction

  // Upper chunks must consume the carry of the chunk below, so fixed-carry ops become
  // their carry-in variants; logical/move ops pass through untouched.
  function automatic alu_op chunk_op(alu_op op, logic first_chunk);
    chunk_op = op;
    if (!first_chunk) begin
      unique case (op)
        ALU_ADD, ALU_ADC, ALU_CMN: chunk_op = ALU_ADC;
        ALU_SUB, ALU_SBC, ALU_CMP: chunk_op = ALU_SBC;
        ALU_RSB, ALU_RSC:          chunk_op = ALU_RSC;
        default:                   chunk_op = op;
      endcase
    end
  endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational W-bit ALU slice: result, carry out and signed overflow.
module core_alu
  import core_alu_seq_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  alu_op          i_op,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  input  logic           i_c,
  output logic [W-1:0]   o_q,
  output logic           o_c,
  output logic           o_v
);

  logic [W-1:0] w_x;
  logic [W-1:0] w_y;
  logic         w_ci;
  logic [W:0]   w_sum;

  always_comb begin
    w_x  = i_a;
    w_y  = i_b;
    w_ci = 1'b0;
    unique case (i_op)
      ALU_ADD, ALU_CMN: w_ci = 1'b0;
      ALU_ADC:          w_ci = i_c;
      ALU_SUB, ALU_CMP: begin w_y = ~i_b; w_ci = 1'b1; end
      ALU_SBC:          begin w_y = ~i_b; w_ci = i_c;  end
      ALU_RSB:          begin w_x = i_b; w_y = ~i_a; w_ci = 1'b1; end
      ALU_RSC:          begin w_x = i_b; w_y = ~i_a; w_ci = i_c;  end
      default:          w_ci = 1'b0;
    endcase
  end

  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{W{1'b0}}, w_ci};

  always_comb begin
    o_q = w_sum[W-1:0];
    o_c = w_sum[W];
    o_v = (w_x[W-1] == w_y[W-1]) && (w_sum[W-1] != w_x[W-1]);
    if (!is_arith(i_op)) begin
      o_c = i_c;
      o_v = 1'b0;
      unique case (i_op)
        ALU_AND, ALU_TST: o_q = i_a & i_b;
        ALU_EOR, ALU_TEQ: o_q = i_a ^ i_b;
        ALU_ORR:          o_q = i_a | i_b;
        ALU_MOV:          o_q = i_b;
        ALU_BIC:          o_q = i_a & ~i_b;
        ALU_MVN:          o_q = ~i_b;
        default:          o_q = i_a & i_b;
      endcase
    end
  end

endmodule

// File: rtl/core_alu_seq.sv
// Runs one DATA_W-bit ALU op through a CHUNK_W-bit core_alu, LSB chunk first, chaining carry
// and folding Z across chunks; result is held until the consumer handshakes.
module core_alu_seq
  import core_alu_seq_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CHUNK_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  alu_op             in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_c_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_q,
  output psr_flags          out_nzcv,
  output logic              out_v_valid
);

  localparam int unsigned N  = DATA_W / CHUNK_W;
  localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [KW-1:0]     r_k;
  alu_op             r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_c;
  logic              r_z;
  logic [DATA_W-1:0] r_q;
  psr_flags          r_nzcv;
  logic              r_v_valid;

  logic [CHUNK_W-1:0] w_a_chunk;
  logic [CHUNK_W-1:0] w_b_chunk;
  logic [CHUNK_W-1:0] w_q;
  logic               w_c;
  logic               w_v;
  logic               w_last;
  alu_op              w_op;

  assign w_last    = (r_k == K_LAST);
  assign w_op      = chunk_op(r_op, r_k == '0);
  assign w_a_chunk = r_a[int'(r_k)*CHUNK_W +: CHUNK_W];
  assign w_b_chunk = r_b[int'(r_k)*CHUNK_W +: CHUNK_W];

  // r_c starts as the issued C and then carries chunk C; logical ops return C unchanged.
  core_alu #(
    .W(CHUNK_W)
  ) u_core_alu (
    .i_op(w_op),
    .i_a (w_a_chunk),
    .i_b (w_b_chunk),
    .i_c (r_c),
    .o_q (w_q),
    .o_c (w_c),
    .o_v (w_v)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_k       <= '0;
      r_op      <= ALU_AND;
      r_a       <= '0;
      r_b       <= '0;
      r_c       <= 1'b0;
      r_z       <= 1'b1;
      r_q       <= '0;
      r_nzcv    <= '0;
      r_v_valid <= 1'b0;
    end else if (flush) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op      <= in_op;
            r_a       <= in_a;
            r_b       <= in_b;
            r_c       <= in_c_in;
            r_k       <= '0;
            r_z       <= 1'b1;
            r_v_valid <= is_arith(in_op);
            r_state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_q[int'(r_k)*CHUNK_W +: CHUNK_W] <= w_q;
          r_c <= w_c;
          r_z <= r_z & (w_q == '0);
          r_k <= r_k + 1'b1;
          if (w_last) begin
            r_nzcv  <= '{n: w_q[CHUNK_W-1], z: r_z & (w_q == '0), c: w_c,
                         v: w_v & r_v_valid};
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign out_q       = r_q;
  assign out_nzcv    = r_nzcv;
  assign out_v_valid = r_v_valid;

endmodule

// File: tb/tb_core_alu_seq.sv
// Directed vector table plus handshake/flush/reset sequences for core_alu_seq (32/16 split).
module tb_core_alu_seq;
  import core_alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  alu_op       in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_c_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_q;
  psr_flags    out_nzcv;
  logic        out_v_valid;
  logic [3:0]  nzcv_bits;

  assign nzcv_bits = out_nzcv;

  core_alu_seq #(
    .DATA_W (32),
    .CHUNK_W(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_c_in    (in_c_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_q      (out_q),
    .out_nzcv   (out_nzcv),
    .out_v_valid(out_v_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    alu_op       op;
    logic [31:0] a;
    logic [31:0] b;
    logic        c_in;
    logic [31:0] q;
    logic [3:0]  nzcv;
    logic        vv;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one op, wait (bounded) for out_valid, report latency in cycles after the accept edge.
  task automatic issue(input alu_op op, input logic [31:0] a, input logic [31:0] b,
                       input logic c, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_c_in  = c;
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int lat;
    issue(v.op, v.a, v.b, v.c_in, lat);
    check({name, "_latency"}, 32'(lat), 32'd2);
    check({name, "_q"}, out_q, v.q);
    check({name, "_nzcv"}, 32'(nzcv_bits), 32'(v.nzcv));
    check({name, "_vvalid"}, 32'(out_v_valid), 32'(v.vv));
    handshake();
  endtask

  initial begin
    int lat;
    int pulses;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = ALU_AND;
    in_a      = '0;
    in_b      = '0;
    in_c_in   = 1'b0;
    out_ready = 1'b0;

    vecs[0]  = '{ALU_ADD, 32'h0000FFFF, 32'h00000001, 1'b1, 32'h00010000, 4'b0000, 1'b1};
    vecs[1]  = '{ALU_CMP, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 4'b0110, 1'b1};
    vecs[2]  = '{ALU_SUB, 32'h00010000, 32'h00000001, 1'b0, 32'h0000FFFF, 4'b0010, 1'b1};
    vecs[3]  = '{ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 4'b1001, 1'b1};
    vecs[4]  = '{ALU_ADC, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 4'b0110, 1'b1};
    vecs[5]  = '{ALU_AND, 32'hFFFF0000, 32'h0000FFFF, 1'b1, 32'h00000000, 4'b0110, 1'b0};
    vecs[6]  = '{ALU_MVN, 32'h00000000, 32'h00000000, 1'b0, 32'hFFFFFFFF, 4'b1000, 1'b0};
    vecs[7]  = '{ALU_RSB, 32'h00000001, 32'h00020000, 1'b0, 32'h0001FFFF, 4'b0010, 1'b1};
    vecs[8]  = '{ALU_SBC, 32'h00000000, 32'h00000000, 1'b0, 32'hFFFFFFFF, 4'b1000, 1'b1};
    vecs[9]  = '{ALU_EOR, 32'h12345678, 32'hFFFFFFFF, 1'b0, 32'hEDCBA987, 4'b1000, 1'b0};
    vecs[10] = '{ALU_CMN, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0111, 1'b1};
    vecs[11] = '{ALU_TEQ, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 32'h00000000, 4'b0110, 1'b0};
    vecs[12] = '{ALU_ORR, 32'h000000F0, 32'h00000F00, 1'b0, 32'h00000FF0, 4'b0000, 1'b0};
    vecs[13] = '{ALU_BIC, 32'hFFFFFFFF, 32'h0000FFFF, 1'b0, 32'hFFFF0000, 4'b1000, 1'b0};
    vecs[14] = '{ALU_SUB, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 4'b0011, 1'b1};
    vecs[15] = '{ALU_RSC, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 4'b0110, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_q", out_q, 32'd0);
    check("reset_nzcv", 32'(nzcv_bits), 32'd0);
    check("reset_v_valid", 32'(out_v_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure in DONE: outputs frozen, next request waits for the handshake.
    issue(ALU_ADD, 32'h0000FFFF, 32'h00000001, 1'b1, lat);
    check("stall_latency", 32'(lat), 32'd2);
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = ALU_SUB;
    in_a     = 32'h00010000;
    in_b     = 32'h00000001;
    in_c_in  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_q", out_q, 32'h00010000);
      check("stall_nzcv", 32'(nzcv_bits), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_hs_in_ready", 32'(in_ready), 32'd1);
    check("post_hs_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("second_accepted", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("second_latency", 32'(lat), 32'd2);
    check("second_q", out_q, 32'h0000FFFF);
    check("second_nzcv", 32'(nzcv_bits), 32'b0010);
    handshake();

    // Flush during RUN k=0, then reset during RUN k=0: no result may ever appear.
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_op    = ALU_ADD;
      in_a     = 32'h11111111;
      in_b     = 32'h22222222;
      in_c_in  = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (pass == 0) flush = 1'b1;
      else           rst_n = 1'b0;
      @(posedge clk);
      #1;
      flush = 1'b0;
      rst_n = 1'b1;
      check(pass == 0 ? "flush_in_ready" : "rst_in_ready", 32'(in_ready), 32'd1);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
        if (out_valid) pulses++;
        @(posedge clk);
        #1;
      end
      check(pass == 0 ? "flush_no_pulse" : "rst_no_pulse", 32'(pulses), 32'd0);
      if (pass == 1) check("rst_out_q", out_q, 32'd0);
      run_vec(vecs[3], pass == 0 ? "after_flush" : "after_rst");
    end

    // Flush beats a simultaneous accept.
    @(negedge clk);
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_beats_accept", 32'(in_ready), 32'd1);
    run_vec(vecs[10], "after_flush_accept");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
